// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The requester drives start and the operands; the adder returns the registered result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  sum, carry_out, zero, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, carry_out, zero, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB first,
// and carries between bits through a flip-flop. A WIDTH-bit add takes WIDTH cycles.
module serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clk,
    input logic         reset,
    serial_adder_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic {StIdle, StAdd} state_t;

    state_t           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             c_q;

    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full-adder cell on the current LSBs plus the result shifted to include this bit.
    always_comb begin
        s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_nxt   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        res_nxt = {s_bit, res_sh_q[WIDTH-1:1]};
    end

    // Control FSM and datapath; result registers only move on the final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_sh_q   <= bus.a;
                        b_sh_q   <= bus.b;
                        c_q      <= bus.cin;
                        cnt_q    <= '0;
                        res_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StAdd;
                    end
                end
                StAdd: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    c_q      <= c_nxt;
                    res_sh_q <= res_nxt;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        sum_q       <= res_nxt;
                        carry_out_q <= c_nxt;
                        zero_q      <= (res_nxt == '0);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of the bit-serial adder at WIDTH=16.
module tb_serial_adder;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present an add request, let one edge accept it, then scramble the operands.
    task automatic go(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    // Wait (bounded) for done after an accepted start; check latency and busy length.
    task automatic wait_done(input string tag, input bit disturb);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = bus.busy ? 1 : 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (disturb && lat == 5) begin
                bus.start = 1'b1;
                bus.a     = 16'hAAAA;
                bus.b     = 16'h5555;
            end else if (disturb && lat == 6) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            if (bus.busy) nbusy++;
        end
        check({tag, " latency"}, lat, 16);
        check({tag, " busy cycles"}, nbusy, 16);
        check({tag, " busy low at done"}, {31'b0, bus.busy}, 0);
    endtask

    task automatic check_res(input string tag, input logic [15:0] s, input logic co,
                             input logic z);
        check({tag, " sum"}, {16'b0, bus.sum}, {16'b0, s});
        check({tag, " carry_out"}, {31'b0, bus.carry_out}, {31'b0, co});
        check({tag, " zero"}, {31'b0, bus.zero}, {31'b0, z});
    endtask

    // One idle cycle after done: the pulse must have dropped and the result held.
    task automatic after_done(input string tag, input logic [15:0] s);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, {31'b0, bus.done}, 0);
        check({tag, " sum held"}, {16'b0, bus.sum}, {16'b0, s});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] ref_sum;
        int          ndone;

        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset sum", {16'b0, bus.sum}, 0);
        check("reset carry_out", {31'b0, bus.carry_out}, 0);
        check("reset zero", {31'b0, bus.zero}, 0);
        check("reset busy", {31'b0, bus.busy}, 0);
        check("reset done", {31'b0, bus.done}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic add.
        go(16'h0003, 16'h0005, 1'b0);
        check("basic busy after start", {31'b0, bus.busy}, 1);
        wait_done("basic", 1'b0);
        check_res("basic", 16'h0008, 1'b0, 1'b0);
        after_done("basic", 16'h0008);

        // Wrap to zero, then all-ones with carry-in.
        go(16'hFFFF, 16'h0001, 1'b0);
        wait_done("wrap", 1'b0);
        check_res("wrap", 16'h0000, 1'b1, 1'b1);
        after_done("wrap", 16'h0000);
        go(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("ones", 1'b0);
        check_res("ones", 16'hFFFF, 1'b1, 1'b0);
        after_done("ones", 16'hFFFF);

        // Start while busy is ignored.
        go(16'h1234, 16'h1111, 1'b0);
        wait_done("ignored", 1'b1);
        check_res("ignored", 16'h2345, 1'b0, 1'b0);
        after_done("ignored", 16'h2345);
        check("ignored no restart", {31'b0, bus.busy}, 0);

        // Reset mid-operation aborts and clears the previous result.
        go(16'h00FF, 16'h0001, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", {31'b0, bus.busy}, 0);
        check("abort done", {31'b0, bus.done}, 0);
        check_res("abort", 16'h0000, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort no done", ndone, 0);
        go(16'h0002, 16'h0002, 1'b0);
        wait_done("after abort", 1'b0);
        check_res("after abort", 16'h0004, 1'b0, 1'b0);
        after_done("after abort", 16'h0004);

        // Back-to-back: next start presented in the done cycle.
        go(16'h0001, 16'h0001, 1'b0);
        wait_done("b2b first", 1'b0);
        check_res("b2b first", 16'h0002, 1'b0, 1'b0);
        go(16'h8000, 16'h8000, 1'b0);
        check("b2b done fell", {31'b0, bus.done}, 0);
        check("b2b busy again", {31'b0, bus.busy}, 1);
        check("b2b sum held", {16'b0, bus.sum}, 32'h0002);
        wait_done("b2b second", 1'b0);
        check_res("b2b second", 16'h0000, 1'b1, 1'b1);
        after_done("b2b second", 16'h0000);

        // Reset and start on the same edge: reset wins.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(posedge clk);
        #1;
        check("collision busy", {31'b0, bus.busy}, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("collision stays idle", {31'b0, bus.busy}, 0);
        check("collision done", {31'b0, bus.done}, 0);

        // Random operands against a+b+cin.
        for (int n = 0; n < 200; n++) begin
            ra      = 16'($urandom);
            rb      = 16'($urandom);
            rc      = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            go(ra, rb, rc);
            wait_done("random", 1'b0);
            check("random result", {15'b0, bus.carry_out, bus.sum}, {15'b0, ref_sum});
            check("random zero", {31'b0, bus.zero}, {31'b0, (ref_sum[15:0] == 16'h0)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
